// File: rtl/axi_lite_bus_a_pkg.sv
// Shared types and constants for the BUS_A AXI4-Lite initiator.
package axi_lite_bus_a_pkg;

    localparam int unsigned BUS_A_ADDR_W         = 32;
    localparam int unsigned BUS_A_DATA_W         = 32;
    localparam int unsigned BUS_A_TIMEOUT_CYCLES = 1024;
    localparam int unsigned RESP_W               = 2;
    localparam int unsigned WDOG_W               = 16;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_bus_a_master.sv
// AXI4-Lite initiator for BUS_A: one outstanding single-word command, registered outputs.
// Optional watchdog flag enabled by defining AXI_LITE_BUS_A_MASTER_TIMEOUT_EN.
module axi_lite_bus_a_master
    import axi_lite_bus_a_pkg::*;
#(
    parameter int unsigned C_M_AXI_BUS_A_ADDR_WIDTH = BUS_A_ADDR_W,
    parameter int unsigned C_M_AXI_BUS_A_DATA_WIDTH = BUS_A_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES           = BUS_A_TIMEOUT_CYCLES
) (
    input  logic                                    SYS_CLK,
    input  logic                                    SYS_RESET,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic                                    cmd_write,
    input  logic [C_M_AXI_BUS_A_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_BUS_A_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_BUS_A_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [C_M_AXI_BUS_A_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                              rsp_resp,
`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
    output logic                                    timeout,
`endif
    output logic [C_M_AXI_BUS_A_ADDR_WIDTH-1:0]     m_axi_BUS_A_AWADDR,
    output logic                                    m_axi_BUS_A_AWVALID,
    input  logic                                    m_axi_BUS_A_AWREADY,
    output logic [C_M_AXI_BUS_A_DATA_WIDTH-1:0]     m_axi_BUS_A_WDATA,
    output logic [C_M_AXI_BUS_A_DATA_WIDTH/8-1:0]   m_axi_BUS_A_WSTRB,
    output logic                                    m_axi_BUS_A_WVALID,
    input  logic                                    m_axi_BUS_A_WREADY,
    input  logic [1:0]                              m_axi_BUS_A_BRESP,
    input  logic                                    m_axi_BUS_A_BVALID,
    output logic                                    m_axi_BUS_A_BREADY,
    output logic [C_M_AXI_BUS_A_ADDR_WIDTH-1:0]     m_axi_BUS_A_ARADDR,
    output logic                                    m_axi_BUS_A_ARVALID,
    input  logic                                    m_axi_BUS_A_ARREADY,
    input  logic [C_M_AXI_BUS_A_DATA_WIDTH-1:0]     m_axi_BUS_A_RDATA,
    input  logic [1:0]                              m_axi_BUS_A_RRESP,
    input  logic                                    m_axi_BUS_A_RVALID,
    output logic                                    m_axi_BUS_A_RREADY
);

    localparam int unsigned AW = C_M_AXI_BUS_A_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_BUS_A_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_BUS_A_DATA_WIDTH / 8;

    state_e              state, state_nxt;
    logic                accept;
    logic                cmd_ready_nxt;
    logic [AW-1:0]       awaddr_nxt, araddr_nxt;
    logic [DW-1:0]       wdata_nxt, rsp_rdata_nxt;
    logic [SW-1:0]       wstrb_nxt;
    logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic                rsp_valid_nxt;
    logic [RESP_W-1:0]   rsp_resp_nxt;

    assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

    // Next state and next value of every registered output; each output flop is fed from here.
    always_comb begin
        state_nxt     = state;
        awaddr_nxt    = m_axi_BUS_A_AWADDR;
        wdata_nxt     = m_axi_BUS_A_WDATA;
        wstrb_nxt     = m_axi_BUS_A_WSTRB;
        araddr_nxt    = m_axi_BUS_A_ARADDR;
        awvalid_nxt   = 1'b0;
        wvalid_nxt    = 1'b0;
        bready_nxt    = 1'b0;
        arvalid_nxt   = 1'b0;
        rready_nxt    = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        state_nxt   = S_WR_AW_W;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_RD_AR;
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR_AW_W: begin
                // AW and W retire independently; leave once both have handshaken.
                awvalid_nxt = m_axi_BUS_A_AWVALID && !m_axi_BUS_A_AWREADY;
                wvalid_nxt  = m_axi_BUS_A_WVALID && !m_axi_BUS_A_WREADY;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = S_WR_B;
                    bready_nxt = 1'b1;
                end
            end
            S_WR_B: begin
                if (m_axi_BUS_A_BVALID) begin
                    state_nxt     = S_RSP;
                    rsp_valid_nxt = 1'b1;
                    rsp_resp_nxt  = m_axi_BUS_A_BRESP;
                    rsp_rdata_nxt = '0;
                end else begin
                    bready_nxt = 1'b1;
                end
            end
            S_RD_AR: begin
                if (m_axi_BUS_A_ARREADY) begin
                    state_nxt  = S_RD_R;
                    rready_nxt = 1'b1;
                end else begin
                    arvalid_nxt = 1'b1;
                end
            end
            S_RD_R: begin
                if (m_axi_BUS_A_RVALID) begin
                    state_nxt     = S_RSP;
                    rsp_valid_nxt = 1'b1;
                    rsp_resp_nxt  = m_axi_BUS_A_RRESP;
                    rsp_rdata_nxt = m_axi_BUS_A_RDATA;
                end else begin
                    rready_nxt = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end else begin
                    rsp_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == S_IDLE);
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RESET) begin
            state               <= S_IDLE;
            cmd_ready           <= 1'b0;
            m_axi_BUS_A_AWADDR  <= '0;
            m_axi_BUS_A_AWVALID <= 1'b0;
            m_axi_BUS_A_WDATA   <= '0;
            m_axi_BUS_A_WSTRB   <= '0;
            m_axi_BUS_A_WVALID  <= 1'b0;
            m_axi_BUS_A_BREADY  <= 1'b0;
            m_axi_BUS_A_ARADDR  <= '0;
            m_axi_BUS_A_ARVALID <= 1'b0;
            m_axi_BUS_A_RREADY  <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_rdata           <= '0;
            rsp_resp            <= RESP_OKAY;
        end else begin
            state               <= state_nxt;
            cmd_ready           <= cmd_ready_nxt;
            m_axi_BUS_A_AWADDR  <= awaddr_nxt;
            m_axi_BUS_A_AWVALID <= awvalid_nxt;
            m_axi_BUS_A_WDATA   <= wdata_nxt;
            m_axi_BUS_A_WSTRB   <= wstrb_nxt;
            m_axi_BUS_A_WVALID  <= wvalid_nxt;
            m_axi_BUS_A_BREADY  <= bready_nxt;
            m_axi_BUS_A_ARADDR  <= araddr_nxt;
            m_axi_BUS_A_ARVALID <= arvalid_nxt;
            m_axi_BUS_A_RREADY  <= rready_nxt;
            rsp_valid           <= rsp_valid_nxt;
            rsp_rdata           <= rsp_rdata_nxt;
            rsp_resp            <= rsp_resp_nxt;
        end
    end

`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              busy;

    assign busy = state inside {S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R};

    // Watchdog only flags a stuck slave; the transaction keeps waiting so AXI rules hold.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RESET) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else if (busy && (wdog_cnt != {WDOG_W{1'b1}})) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if ((wdog_cnt + WDOG_W'(1)) >= WDOG_W'(TIMEOUT_CYCLES)) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    // Parameter kept so both builds share one instantiation interface.
    logic [WDOG_W-1:0] unused_timeout_cycles;
    assign unused_timeout_cycles = WDOG_W'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_axi_lite_bus_a_master.sv
// Directed self-checking bench for axi_lite_bus_a_master; slave side driven cycle by cycle.
// Watchdog scenario runs only when AXI_LITE_BUS_A_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_bus_a_master;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
    logic        timeout;
`endif
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks   = 0;
    int failures = 0;

    always #5 SYS_CLK = ~SYS_CLK;

    axi_lite_bus_a_master #(.TIMEOUT_CYCLES(8)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RESET(SYS_RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
        .timeout(timeout),
`endif
        .m_axi_BUS_A_AWADDR(awaddr), .m_axi_BUS_A_AWVALID(awvalid), .m_axi_BUS_A_AWREADY(awready),
        .m_axi_BUS_A_WDATA(wdata), .m_axi_BUS_A_WSTRB(wstrb), .m_axi_BUS_A_WVALID(wvalid),
        .m_axi_BUS_A_WREADY(wready), .m_axi_BUS_A_BRESP(bresp), .m_axi_BUS_A_BVALID(bvalid),
        .m_axi_BUS_A_BREADY(bready), .m_axi_BUS_A_ARADDR(araddr), .m_axi_BUS_A_ARVALID(arvalid),
        .m_axi_BUS_A_ARREADY(arready), .m_axi_BUS_A_RDATA(rdata), .m_axi_BUS_A_RRESP(rresp),
        .m_axi_BUS_A_RVALID(rvalid), .m_axi_BUS_A_RREADY(rready)
    );

    // Advance to 1 time unit after the next rising edge: outputs settled, inputs safe to change.
    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic rsp_accept();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        SYS_RESET = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        step(); step();
        checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_handshakes got=%b exp=000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
        checks++; if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        checks++; if ({awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp} !== 134'b0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp}); end
        SYS_RESET = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        awready = 1; wready = 1;
        step();
        cmd_valid = 0;
        checks++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin
            failures++; $display("FAIL wr0_n1_valids got=%b exp=110", {awvalid, wvalid, cmd_ready}); end
        checks++; if (awaddr !== 32'h10 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
            failures++; $display("FAIL wr0_n1_payload got=%h/%h/%h exp=10/deadbeef/f", awaddr, wdata, wstrb); end
        step();
        awready = 0; wready = 0;
        checks++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
            failures++; $display("FAIL wr0_n2_bready got=%b exp=0010", {awvalid, wvalid, bready, rsp_valid}); end
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || bready !== 1'b0) begin
            failures++; $display("FAIL wr0_n3_rsp got=v%b r%b d%h br%b exp=v1 r00 d0 br0", rsp_valid, rsp_resp, rsp_rdata, bready); end
        rsp_accept();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL wr0_done got=v%b cr%b exp=v0 cr1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read_wait();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0014; arready = 1;
        step();
        cmd_valid = 0;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h14 || awvalid !== 1'b0) begin
            failures++; $display("FAIL rd_n1_ar got=v%b a%h aw%b exp=v1 a14 aw0", arvalid, araddr, awvalid); end
        step();
        arready = 0;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin
            failures++; $display("FAIL rd_n2_rready got=ar%b rr%b exp=ar0 rr1", arvalid, rready); end
        step(); step();
        checks++; if (rready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rd_n4_wait got=rr%b v%b exp=rr1 v0", rready, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rd_n5_early got=%b exp=0", rsp_valid); end
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
        step();
        rvalid = 0; rdata = 32'h0BAD_0BAD; rresp = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b10 || rready !== 1'b0) begin
            failures++; $display("FAIL rd_n6_rsp got=v%b d%h r%b rr%b exp=v1 d12345678 r10 rr0", rsp_valid, rsp_rdata, rsp_resp, rready); end
        rsp_accept();
    endtask

    task automatic test_write_w_first();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'h3;
        step();
        cmd_valid = 0; wready = 1;
        step();
        wready = 0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin
            failures++; $display("FAIL wf_n2_w_done got=%b exp=100", {awvalid, wvalid, bready}); end
        step();
        checks++; if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h40) begin
            failures++; $display("FAIL wf_n3_aw_hold got=%b a%h exp=100 a40", {awvalid, wvalid, bready}, awaddr); end
        awready = 1;
        step();
        awready = 0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin
            failures++; $display("FAIL wf_n4_bready got=%b exp=001", {awvalid, wvalid, bready}); end
        bvalid = 1; bresp = 2'b11;
        step();
        bvalid = 0; bresp = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL wf_rsp got=v%b r%b d%h exp=v1 r11 d0", rsp_valid, rsp_resp, rsp_rdata); end
        rsp_accept();
    endtask

    task automatic test_rsp_backpressure();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0080; arready = 1;
        step();
        cmd_valid = 0;
        step();
        arready = 0; rvalid = 1; rdata = 32'hA1B2_C3D4; rresp = 2'b01;
        step();
        rvalid = 0;
        cmd_valid = 1; cmd_write = 1;
        for (int i = 0; i < 5; i++) begin
            rdata = 32'h1111_1111 * i; rresp = 2'(i);
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA1B2_C3D4 || rsp_resp !== 2'b01 || cmd_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d got=v%b d%h r%b cr%b exp=v1 da1b2c3d4 r01 cr0", i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready); end
            step();
        end
        cmd_valid = 0;
        rsp_accept();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
            failures++; $display("FAIL bp_release got=v%b cr%b aw%b exp=v0 cr1 aw0", rsp_valid, cmd_ready, awvalid); end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        awready = 1; wready = 1; arready = 1; rsp_ready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'hF;
        rdata = 32'hCAFE_F00D; rresp = 2'b01; bresp = 2'b00;
        for (int c = 0; c < 10; c++) begin
            bvalid = bready; rvalid = rready;
            if (cmd_valid && cmd_ready) acc.push_back(c);
            if (c == 3) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
                    failures++; $display("FAIL b2b_wr_rsp got=v%b r%b d%h exp=v1 r00 d0", rsp_valid, rsp_resp, rsp_rdata); end
            end
            if (c == 7) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b01 || rsp_rdata !== 32'hCAFE_F00D) begin
                    failures++; $display("FAIL b2b_rd_rsp got=v%b r%b d%h exp=v1 r01 dcafef00d", rsp_valid, rsp_resp, rsp_rdata); end
            end
            step();
            if (acc.size() == 1) begin cmd_write = 0; cmd_addr = 32'h24; end
            if (acc.size() == 2) cmd_valid = 0;
        end
        bvalid = 0; rvalid = 0; awready = 0; wready = 0; arready = 0; rsp_ready = 0;
        checks++; if (acc.size() != 2 || acc[0] != 0 || acc[1] != 4) begin
            failures++; $display("FAIL b2b_accept_spacing got=n%0d first%0d second%0d exp=n2 first0 second4",
                                 acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1); end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0030; arready = 1;
        step();
        cmd_valid = 0;
        step();
        arready = 0;
        checks++; if (rready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_in_rd_r got=%b exp=1", rready); end
        SYS_RESET = 1'b1;
        step();
        checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin
            failures++; $display("FAIL rst_mid_cleared got=%b exp=0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}); end
        SYS_RESET = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1 || rready !== 1'b0) begin
            failures++; $display("FAIL rst_mid_idle got=cr%b rr%b exp=cr1 rr0", cmd_ready, rready); end
    endtask

`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        awready = 1; wready = 1;
        step();
        cmd_valid = 0;
        step();
        awready = 0; wready = 0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (timeout !== 1'b0) begin
            failures++; $display("FAIL to_before_limit got=%b exp=0", timeout); end
        step();
        checks++; if (timeout !== 1'b1 || bready !== 1'b1) begin
            failures++; $display("FAIL to_at_limit got=to%b br%b exp=to1 br1", timeout, bready); end
        bvalid = 1;
        step();
        bvalid = 0;
        rsp_accept();
        checks++; if (timeout !== 1'b1) begin
            failures++; $display("FAIL to_sticky got=%b exp=1", timeout); end
        cmd_valid = 1; cmd_write = 0; arready = 1;
        step();
        cmd_valid = 0;
        checks++; if (timeout !== 1'b0) begin
            failures++; $display("FAIL to_clear_on_accept got=%b exp=0", timeout); end
        step();
        arready = 0; rvalid = 1;
        step();
        rvalid = 0;
        rsp_accept();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_write_w_first();
        test_rsp_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_LITE_BUS_A_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
